// File: rtl/vc_allocator_if.sv
// Request/grant/release bundle between the input VCs of one output port and its VC allocator.
interface vc_allocator_if #(
  parameter int NUM_REQ = 5,
  parameter int NUM_VC  = 2,
  parameter int VC_W    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
);
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_VC-1:0]  release_i;
  logic [NUM_REQ-1:0] grant_o;
  logic [VC_W-1:0]    grant_vc_o;
  logic [NUM_VC-1:0]  vc_busy_o;
  logic               err_o;

  modport master (
    output req_i, release_i,
    input  grant_o, grant_vc_o, vc_busy_o, err_o
  );

  modport slave (
    input  req_i, release_i,
    output grant_o, grant_vc_o, vc_busy_o, err_o
  );
endinterface

// File: rtl/vc_allocator.sv
// Round-robin VC allocator: grants at most one requester per cycle the lowest FREE downstream VC.
module vc_allocator #(
  parameter int NUM_REQ = 5,
  parameter int NUM_VC  = 2,
  parameter int VC_W    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic           clk,
  input  logic           rst,
  vc_allocator_if.slave  bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [0:0] FREE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [NUM_VC-1:0]  r_vc_st;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] r_grant;
  logic [VC_W-1:0]    r_grant_vc;
  logic               r_err;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [NUM_VC-1:0]  w_rel;
  logic [NUM_VC-1:0]  w_free;
  logic               w_win_vld;
  logic [PTR_W-1:0]   w_win;
  logic               w_vc_vld;
  logic [VC_W-1:0]    w_vc;
  logic               w_gnt;

  // The requester shown on grant_o this cycle sits out so it cannot win twice in a row.
  assign w_elig   = bus.req_i & ~r_grant;
  assign w_rel    = bus.release_i;
  assign w_gnt    = w_win_vld & w_vc_vld;
  assign w_win_oh = NUM_REQ'(1) << w_win;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) w_free[v] = (r_vc_st[v] == FREE);
  end

  always_comb begin : rr_pick
    int idx;
    idx       = 0;
    w_win_vld = 1'b0;
    w_win     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_win_vld && w_elig[idx]) begin
        w_win_vld = 1'b1;
        w_win     = PTR_W'(idx);
      end
    end
  end

  always_comb begin : vc_pick
    w_vc_vld = 1'b0;
    w_vc     = '0;
    for (int v = NUM_VC - 1; v >= 0; v--) begin
      if (w_free[v]) begin
        w_vc_vld = 1'b1;
        w_vc     = VC_W'(v);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vc_st    <= '0;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_grant_vc <= '0;
      r_err      <= 1'b0;
    end else begin
      // Releasing a FREE VC (even one being allocated now) is a protocol error with no effect.
      r_err <= |(w_rel & w_free);
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_rel[v] && r_vc_st[v] == BUSY) r_vc_st[v] <= FREE;
      end
      if (w_gnt) begin
        r_vc_st[w_vc] <= BUSY;
        r_rr_ptr      <= (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);
        r_grant       <= w_win_oh;
        r_grant_vc    <= w_vc;
      end else begin
        r_grant    <= '0;
        r_grant_vc <= '0;
      end
    end
  end

  assign bus.grant_o    = r_grant;
  assign bus.grant_vc_o = r_grant_vc;
  assign bus.vc_busy_o  = r_vc_st;
  assign bus.err_o      = r_err;
endmodule

// File: tb/tb_vc_allocator.sv
// Self-checking bench for vc_allocator: directed vector table, corner sequences, random vs. reference model.
module tb_vc_allocator;
  localparam int NR = 5;
  localparam int NV = 2;
  localparam int VW = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vc_allocator_if #(.NUM_REQ(NR), .NUM_VC(NV), .VC_W(VW)) bus ();
  vc_allocator #(.NUM_REQ(NR), .NUM_VC(NV), .VC_W(VW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: VC occupancy list, pointer as integer, last grant as requester number.
  bit m_busy[NV];
  int m_rr  = 0;
  int m_gnt = -1;
  int m_gvc = 0;
  bit m_err = 0;

  task automatic model_step(input bit r, input logic [NR-1:0] rq, input logic [NV-1:0] rl);
    int win, fv;
    bit nb[NV];
    if (r) begin
      foreach (m_busy[v]) m_busy[v] = 0;
      m_rr = 0; m_gnt = -1; m_gvc = 0; m_err = 0;
      return;
    end
    win = -1; fv = -1; m_err = 0;
    for (int v = 0; v < NV; v++) begin
      if (rl[v] && !m_busy[v]) m_err = 1;
      if (!m_busy[v] && fv < 0) fv = v;
      nb[v] = m_busy[v] && !rl[v];
    end
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (m_rr + k) % NR;
      if (win < 0 && rq[idx] && idx != m_gnt) win = idx;
    end
    if (fv < 0) win = -1;
    if (win >= 0) begin
      nb[fv] = 1;
      m_rr   = (win + 1) % NR;
      m_gnt  = win;
      m_gvc  = fv;
    end else begin
      m_gnt = -1;
      m_gvc = 0;
    end
    m_busy = nb;
  endtask

  task automatic tick();
    model_step(rst, bus.req_i, bus.release_i);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model();
    logic [NR-1:0] eg;
    logic [NV-1:0] eb;
    eg = '0;
    if (m_gnt >= 0) eg[m_gnt] = 1'b1;
    for (int v = 0; v < NV; v++) eb[v] = m_busy[v];
    chk("rnd_grant", 32'(bus.grant_o), 32'(eg));
    chk("rnd_grant_vc", 32'(bus.grant_vc_o), 32'(m_gvc));
    chk("rnd_busy", 32'(bus.vc_busy_o), 32'(eb));
    chk("rnd_err", 32'(bus.err_o), 32'(m_err));
  endtask

  typedef struct packed {
    logic          rst;
    logic [NR-1:0] req;
    logic [NV-1:0] rel;
    logic [NR-1:0] g;
    logic [VW-1:0] gv;
    logic [NV-1:0] b;
    logic          e;
  } vec_t;

  vec_t tbl[15];

  initial begin
    rst = 1'b1;
    bus.req_i = '0;
    bus.release_i = '0;

    tbl[0]  = '{1'b1, 5'b00000, 2'b00, 5'b00000, 1'b0, 2'b00, 1'b0};
    tbl[1]  = '{1'b1, 5'b11111, 2'b11, 5'b00000, 1'b0, 2'b00, 1'b0};
    tbl[2]  = '{1'b0, 5'b00001, 2'b00, 5'b00001, 1'b0, 2'b01, 1'b0};
    tbl[3]  = '{1'b0, 5'b00001, 2'b00, 5'b00000, 1'b0, 2'b01, 1'b0};
    tbl[4]  = '{1'b0, 5'b00000, 2'b01, 5'b00000, 1'b0, 2'b00, 1'b0};
    tbl[5]  = '{1'b0, 5'b00000, 2'b01, 5'b00000, 1'b0, 2'b00, 1'b1};
    tbl[6]  = '{1'b0, 5'b00000, 2'b00, 5'b00000, 1'b0, 2'b00, 1'b0};
    tbl[7]  = '{1'b0, 5'b00110, 2'b00, 5'b00010, 1'b0, 2'b01, 1'b0};
    tbl[8]  = '{1'b0, 5'b00100, 2'b00, 5'b00100, 1'b1, 2'b11, 1'b0};
    tbl[9]  = '{1'b0, 5'b01000, 2'b00, 5'b00000, 1'b0, 2'b11, 1'b0};
    tbl[10] = '{1'b0, 5'b01000, 2'b11, 5'b00000, 1'b0, 2'b00, 1'b0};
    tbl[11] = '{1'b0, 5'b01000, 2'b00, 5'b01000, 1'b0, 2'b01, 1'b0};
    tbl[12] = '{1'b0, 5'b10000, 2'b10, 5'b10000, 1'b1, 2'b11, 1'b1};
    tbl[13] = '{1'b0, 5'b00000, 2'b11, 5'b00000, 1'b0, 2'b00, 1'b0};
    tbl[14] = '{1'b1, 5'b11111, 2'b11, 5'b00000, 1'b0, 2'b00, 1'b0};

    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst;
      bus.req_i = tbl[i].req;
      bus.release_i = tbl[i].rel;
      tick();
      chk($sformatf("tbl%0d_grant", i), 32'(bus.grant_o), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_grant_vc", i), 32'(bus.grant_vc_o), 32'(tbl[i].gv));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.vc_busy_o), 32'(tbl[i].b));
      chk($sformatf("tbl%0d_err", i), 32'(bus.err_o), 32'(tbl[i].e));
    end

    // Rotation under full load with releases two cycles after each grant.
    begin
      int seq[$];
      int cnt[NV];
      int exp_seq[6];
      logic [NV-1:0] rl;
      exp_seq = '{0, 1, 2, 3, 4, 0};
      foreach (cnt[v]) cnt[v] = 0;
      rst = 1'b1; bus.req_i = '0; bus.release_i = '0;
      tick();
      rst = 1'b0; bus.req_i = '1;
      for (int c = 0; c < 100 && seq.size() < 6; c++) begin
        tick();
        if (bus.grant_o != '0) begin
          for (int i = 0; i < NR; i++) if (bus.grant_o[i]) seq.push_back(i);
          cnt[bus.grant_vc_o] = 2;
        end
        rl = '0;
        for (int v = 0; v < NV; v++) begin
          if (cnt[v] > 0) begin
            cnt[v]--;
            if (cnt[v] == 0) rl[v] = 1'b1;
          end
        end
        bus.release_i = rl;
      end
      chk("rot_count", 32'(seq.size()), 32'd6);
      for (int i = 0; i < seq.size(); i++) chk($sformatf("rot_%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
    end

    // Starvation with both VCs busy, then release of VC1, then reset with requests pending.
    rst = 1'b1; bus.req_i = '0; bus.release_i = '0;
    tick();
    rst = 1'b0; bus.req_i = 5'b00001;
    tick();
    bus.req_i = 5'b00010;
    tick();
    chk("full_busy", 32'(bus.vc_busy_o), 32'h3);
    bus.req_i = 5'b00100;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("full_nogrant", 32'(bus.grant_o), 32'h0);
      chk("full_noerr", 32'(bus.err_o), 32'h0);
    end
    bus.release_i = 2'b10;
    tick();
    chk("rel1_busy", 32'(bus.vc_busy_o), 32'h1);
    chk("rel1_nogrant", 32'(bus.grant_o), 32'h0);
    bus.release_i = 2'b00;
    tick();
    chk("rel1_grant", 32'(bus.grant_o), 32'h04);
    chk("rel1_grant_vc", 32'(bus.grant_vc_o), 32'h1);
    bus.req_i = 5'b11000;
    tick();
    chk("pend_busy", 32'(bus.vc_busy_o), 32'h3);
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(bus.vc_busy_o), 32'h0);
    chk("midrst_grant", 32'(bus.grant_o), 32'h0);
    chk("midrst_err", 32'(bus.err_o), 32'h0);
    rst = 1'b0;
    tick();
    chk("postrst_grant", 32'(bus.grant_o), 32'h08);
    chk("postrst_grant_vc", 32'(bus.grant_vc_o), 32'h0);

    // Random traffic against the reference model.
    rst = 1'b1; bus.req_i = '0; bus.release_i = '0;
    tick();
    chk_model();
    for (int c = 0; c < 600; c++) begin
      logic [NV-1:0] rl;
      rst = ($urandom_range(0, 49) == 0);
      bus.req_i = 5'($urandom);
      for (int v = 0; v < NV; v++) rl[v] = ($urandom_range(0, 3) == 0);
      bus.release_i = rl;
      tick();
      chk_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vc_allocator.md
VC_ALLOCATOR -- requirements
Module: vc_allocator

Interface
REQ-001 Parameter NUM_REQ, default 5, SHALL set the number of requesting input VCs sharing one output port.
REQ-002 Parameter NUM_VC, default 2, SHALL set the number of downstream VCs on that output port.
REQ-003 Parameter VC_W, default $clog2(NUM_VC) (minimum 1), SHALL set the VC index width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 req_i  input  NUM_REQ  SHALL carry per-requester VC-allocation requests, level, held until granted.
REQ-007 release_i  input  NUM_VC  SHALL carry per-VC release pulses, asserted when a tail or headtail flit leaves on that VC.
REQ-008 grant_o  output  NUM_REQ  SHALL be a one-hot, one-cycle grant pulse.
REQ-009 grant_vc_o  output  VC_W  SHALL give the downstream VC index allocated with grant_o; valid only while grant_o is non-zero.
REQ-010 vc_busy_o  output  NUM_VC  SHALL show per-VC occupancy: 1 = BUSY, 0 = FREE.
REQ-011 err_o  output  1  SHALL be a one-cycle protocol-error pulse.

Function
REQ-012 Each VC SHALL carry a two-state FSM, FREE or BUSY. FREE->BUSY on allocation. BUSY->FREE on release_i.
REQ-013 Eligible requesters in a cycle SHALL be those with req_i=1 and grant_o=0 in that same cycle, so the requester just granted cannot win twice.
REQ-014 When at least one requester is eligible and at least one VC is FREE, the block SHALL choose one winner by round-robin, searching upward (with wrap) from rr_ptr.
REQ-015 The allocated VC SHALL be the lowest-index FREE VC.
REQ-016 Grant latency SHALL be 1 cycle: the decision in cycle t appears on grant_o/grant_vc_o in t+1, and vc_busy_o for that VC reads 1 in t+1.
REQ-017 rr_ptr SHALL update to (winner+1) mod NUM_REQ only on a grant, and SHALL hold otherwise.
REQ-018 At most one grant SHALL be issued per cycle.
REQ-019 With no FREE VC, no grant SHALL issue; requests stay pending with no error.
REQ-020 A release_i on a BUSY VC SHALL free it at the next edge. That VC SHALL NOT be granted in the same cycle the release is sampled; it becomes eligible one cycle later.
REQ-021 A release_i on a FREE VC, including a VC whose allocation decision is being made in the same cycle, SHALL pulse err_o in the next cycle and change no state.
REQ-022 Multiple release_i bits in one cycle SHALL each be handled independently.
REQ-023 grant_o SHALL be 0 and grant_vc_o SHALL be 0 whenever no grant issues.
REQ-024 If release_i has bits at or above NUM_VC (non-power-of-2 width), those bits SHALL be ignored.

Reset
REQ-025 While rst=1, the block SHALL drive grant_o=0, grant_vc_o=0, vc_busy_o=0 (all FREE), err_o=0, and rr_ptr=0 at the clock edge.
REQ-026 Reset asserted mid-operation SHALL discard all allocations and pending decisions. The first grant SHALL be no earlier than 1 cycle after the first non-reset edge.
REQ-027 Inputs SHALL be ignored during reset, and no err_o SHALL arise from them.

Verification
REQ-028 After reset, req_i=5'b00001 held -> grant_o=5'b00001, grant_vc_o=0 one cycle later; vc_busy_o=2'b01; no second grant while req_i stays high for one more cycle.
REQ-029 req_i=5'b11111 held, release_i pulsed on each granted VC two cycles after its grant -> grants rotate 0,1,2,3,4,0 and each requester is granted before any is granted twice.
REQ-030 Both VCs BUSY, req_i=5'b00100 held, no release for 10 cycles -> grant_o stays 0 and err_o stays 0. Then release_i=2'b10 -> vc_busy_o=2'b01 next cycle, grant_o=5'b00100 with grant_vc_o=1 the cycle after.
REQ-031 release_i=2'b01 while vc_busy_o=2'b00 -> err_o=1 for exactly one cycle, vc_busy_o unchanged.
REQ-032 Both VCs BUSY with requests pending, rst=1 for one cycle -> vc_busy_o=0, grant_o=0, rr_ptr=0. Next grant goes to the lowest-index pending requester on VC 0.
REQ-033 release_i=2'b11 simultaneously with both VCs BUSY -> vc_busy_o=2'b00 next cycle and no err_o.
